// File: rtl/multi_core_store_controller.sv
// Round-robin multi-core store controller: arbitrates per-core store
// requests and issues 1..MAX_WORDS word bursts to shared memory.
module multi_core_store_controller #(
  parameter int NUM_CORES  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 4,
  localparam int LEN_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clk,
  input  logic                            rstN,
  input  logic [NUM_CORES-1:0]            storeReq,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] storeAddr,
  input  logic [NUM_CORES*LEN_W-1:0]      storeLen,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] storeData,
  input  logic                            memReady,
  output logic                            memWrite,
  output logic [ADDR_WIDTH-1:0]           memAddr,
  output logic [DATA_WIDTH-1:0]           memData,
  output logic [NUM_CORES-1:0]            grant,
  output logic [NUM_CORES-1:0]            wordAck,
  output logic [NUM_CORES-1:0]            storeDone,
  output logic                            busy
);

  typedef enum logic [1:0] {
    IDLE, GRANT, STORE, DONE
  } state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      owner_q;
  logic [IDX_W-1:0]      rr_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt_q;

  logic [ADDR_WIDTH-1:0] addr_a [NUM_CORES];
  logic [LEN_W-1:0]      len_a  [NUM_CORES];
  logic [DATA_WIDTH-1:0] data_a [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slice
    assign addr_a[g] = storeAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_a[g]  = storeLen[g*LEN_W +: LEN_W];
    assign data_a[g] = storeData[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] scan_idx;

  // First requester at or above rr_q, wrapping past the top core
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      scan_idx = IDX_W'((32'(rr_q) + k) % NUM_CORES);
      if (!win_vld && storeReq[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_vld) begin
            owner_q <= win_idx;
            base_q  <= addr_a[win_idx];
            len_q   <= len_a[win_idx];
            cnt_q   <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: state_q <= STORE;
        STORE: begin
          if (memReady) begin
            if (cnt_q == len_q) state_q <= DONE;
            else cnt_q <= cnt_q + LEN_W'(1);
          end
        end
        DONE: begin
          rr_q <= (owner_q == IDX_W'(NUM_CORES - 1)) ?
                  '0 : owner_q + IDX_W'(1);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [NUM_CORES-1:0] owner_oh;

  assign owner_oh  = NUM_CORES'(1) << owner_q;
  assign busy      = (state_q != IDLE);
  assign memWrite  = (state_q == STORE);
  assign grant     = busy ? owner_oh : '0;
  assign memAddr   = memWrite ? base_q + ADDR_WIDTH'(cnt_q) : '0;
  assign memData   = memWrite ? data_a[owner_q] : '0;
  assign wordAck   = (memWrite && memReady) ? owner_oh : '0;
  assign storeDone = (state_q == DONE) ? owner_oh : '0;

endmodule

// File: tb/tb_multi_core_store_controller.sv
// Bench for multi_core_store_controller: directed vectors, corner
// sequences and random traffic against a cycle reference model.
module tb_multi_core_store_controller;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstN;
  logic [N-1:0]    storeReq;
  logic [N*AW-1:0] storeAddr;
  logic [N*LW-1:0] storeLen;
  logic [N*DW-1:0] storeData;
  logic            memReady;
  logic            memWrite;
  logic [AW-1:0]   memAddr;
  logic [DW-1:0]   memData;
  logic [N-1:0]    grant;
  logic [N-1:0]    wordAck;
  logic [N-1:0]    storeDone;
  logic            busy;

  multi_core_store_controller #(
    .NUM_CORES(N), .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW), .MAX_WORDS(4)
  ) dut (
    .clk(clk), .rstN(rstN),
    .storeReq(storeReq), .storeAddr(storeAddr),
    .storeLen(storeLen), .storeData(storeData),
    .memReady(memReady), .memWrite(memWrite),
    .memAddr(memAddr), .memData(memData),
    .grant(grant), .wordAck(wordAck),
    .storeDone(storeDone), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  logic [DW-1:0] salt [N];
  int            widx [N];
  int            done_cnt [N];
  logic [N-1:0]  ack_seen, done_seen, gnt_seen, prev_gnt;
  int            ack_cnt = 0, store_cycles = 0, cyc_n = 0;
  int            gq [$];
  int            gcyc [$];

  typedef struct {
    int            core;
    int            addr;
    logic [DW-1:0] data;
  } beat_t;
  beat_t wq [$];

  // Reference: owner -1 means free; grt/fin mark the
  // one-cycle handover phases around the data beats.
  int m_own = -1, m_beat = 0, m_rr = 0, m_base = 0, m_len = 0;
  bit m_grt = 0, m_fin = 0;

  typedef struct {
    int         core;
    int         addr;
    int         len;
    logic [7:0] rdy;
    int         cycles;
    int         first;
    int         last;
  } vec_t;
  vec_t vt [4];

  function automatic logic [63:0] outs();
    return 64'({busy, grant, wordAck, storeDone,
                memWrite, memAddr, memData});
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc_n);
    end
  endtask

  task automatic apply_data();
    for (int i = 0; i < N; i++)
      storeData[i*DW +: DW] = salt[i] + DW'(widx[i]);
  endtask

  task automatic start(input int c, input int a,
                       input int l, input logic [DW-1:0] s);
    storeReq[c] = 1'b1;
    storeAddr[c*AW +: AW] = AW'(a);
    storeLen[c*LW +: LW] = LW'(l);
    salt[c] = s;
    widx[c] = 0;
    apply_data();
  endtask

  task automatic monitor();
    logic [N-1:0]  oh, e_ack, e_done;
    logic          ew;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    bit            found;
    beat_t         b;
    cyc_n++;
    if (!rstN) begin
      m_own = -1; m_grt = 0; m_fin = 0;
      m_beat = 0; m_rr = 0;
      ack_seen = '0; done_seen = '0;
      gnt_seen = '0; prev_gnt = '0;
      check("in_reset", outs(), 64'd0);
      return;
    end
    oh = '0;
    if (m_own >= 0) oh[m_own] = 1'b1;
    ew = (m_own >= 0) && !m_grt && !m_fin;
    e_addr = '0;
    e_data = '0;
    if (ew) begin
      e_addr = AW'((m_base + m_beat) % (1 << AW));
      e_data = storeData[m_own*DW +: DW];
    end
    e_ack  = (ew && memReady) ? oh : '0;
    e_done = m_fin ? oh : '0;
    check("cycle", outs(),
          64'({m_own >= 0, oh, e_ack, e_done, ew, e_addr, e_data}));
    if (memWrite) store_cycles++;
    if (memWrite && memReady) begin
      b.core = -1;
      for (int i = 0; i < N; i++) if (grant[i]) b.core = i;
      b.addr = int'(memAddr);
      b.data = memData;
      wq.push_back(b);
    end
    ack_cnt += $countones(wordAck);
    for (int i = 0; i < N; i++) if (storeDone[i]) done_cnt[i]++;
    if (grant != '0 && prev_gnt == '0) begin
      for (int i = 0; i < N; i++) if (grant[i]) gq.push_back(i);
      gcyc.push_back(cyc_n);
    end
    prev_gnt  = grant;
    ack_seen  = wordAck;
    done_seen = storeDone;
    gnt_seen  = grant;
    if (m_own < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!found && storeReq[j]) begin
          found = 1;
          m_own = j; m_grt = 1; m_beat = 0;
          m_base = int'(storeAddr[j*AW +: AW]);
          m_len = int'(storeLen[j*LW +: LW]);
        end
      end
    end else if (m_grt) begin
      m_grt = 0;
    end else if (m_fin) begin
      m_rr = (m_own + 1) % N;
      m_own = -1;
      m_fin = 0;
    end else if (memReady) begin
      if (m_beat == m_len) m_fin = 1;
      else m_beat++;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i]) widx[i]++;
      if (done_seen[i]) storeReq[i] = 1'b0;
    end
    if (mode == 1) begin
      for (int i = 0; i < N; i++)
        if (!storeReq[i]) start(i, 16 * i, 0, $urandom);
    end else if (mode == 2) begin
      memReady = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!storeReq[i]) begin
          if ($urandom_range(0, 3) == 0)
            start(i, int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 3)), $urandom);
        end else if (gnt_seen[i] && $urandom_range(0, 7) == 0) begin
          storeAddr[i*AW +: AW] = AW'($urandom);
          storeLen[i*LW +: LW] = LW'($urandom);
        end
      end
    end
    apply_data();
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    storeReq = '0;
    for (int i = 0; i < N; i++) widx[i] = 0;
    apply_data();
    cyc();
    cyc();
    rstN = 1'b1;
  endtask

  task automatic wait_done(input int c, input int d0,
                           input int bound, input string nm);
    int t;
    t = 0;
    while (done_cnt[c] == d0 && t < bound) begin
      cyc();
      t++;
    end
    check(nm, 64'(done_cnt[c] - d0), 64'd1);
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int t;
    t = 0;
    while ((storeReq != '0 || busy) && t < bound) begin
      cyc();
      t++;
    end
    check(nm, 64'({storeReq, busy}), 64'd0);
  endtask

  function automatic logic pat(input logic [7:0] r, input int t);
    int s;
    s = t - 2;
    if (s < 0 || s > 7) return 1'b1;
    return r[s];
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g0, d0, s0, q0, a0, t, c;
    logic [DW-1:0] sv;
    vt[0] = '{2, 'h100, 3, 8'b1111_1001, 6, 'h100, 'h103};
    vt[1] = '{1, 'h3FE, 3, 8'hFF,        4, 'h3FE, 'h001};
    vt[2] = '{3, 'h055, 0, 8'b1111_1000, 4, 'h055, 'h055};
    vt[3] = '{0, 'h200, 1, 8'b1111_1010, 4, 'h200, 'h201};

    rstN = 1'b0;
    storeReq = '0; storeAddr = '0; storeLen = '0;
    storeData = '0; memReady = 1'b0;
    ack_seen = '0; done_seen = '0;
    gnt_seen = '0; prev_gnt = '0;
    for (int i = 0; i < N; i++) begin
      salt[i] = '0; widx[i] = 0; done_cnt[i] = 0;
    end
    #2;
    check("reset_outputs", outs(), 64'd0);
    cyc();
    cyc();
    rstN = 1'b1;

    // Single one-word store
    memReady = 1'b1;
    start(0, 'h010, 0, 32'hDEADBEEF);
    cyc();
    check("t1_grant", 64'({busy, grant, memWrite}),
          64'({1'b1, 4'b0001, 1'b0}));
    cyc();
    check("t1_write", 64'({memWrite, memAddr, memData, wordAck}),
          64'({1'b1, 10'h010, 32'hDEADBEEF, 4'b0001}));
    cyc();
    check("t1_done", 64'({storeDone, grant, memWrite}),
          64'({4'b0001, 4'b0001, 1'b0}));
    cyc();
    check("t1_idle", 64'({busy, grant}), 64'd0);

    // Table of single bursts with scripted memReady stalls
    for (int v = 0; v < 4; v++) begin
      c = vt[v].core;
      sv = $urandom;
      d0 = done_cnt[c]; s0 = store_cycles;
      q0 = wq.size(); a0 = ack_cnt;
      start(c, vt[v].addr, vt[v].len, sv);
      t = 0;
      while (done_cnt[c] == d0 && t < 40) begin
        memReady = pat(vt[v].rdy, t);
        cyc();
        t++;
      end
      check("vec_done", 64'(done_cnt[c] - d0), 64'd1);
      check("vec_store_cycles", 64'(store_cycles - s0),
            64'(vt[v].cycles));
      check("vec_acks", 64'(ack_cnt - a0), 64'(vt[v].len + 1));
      check("vec_beats", 64'(wq.size() - q0), 64'(vt[v].len + 1));
      if (wq.size() > q0) begin
        check("vec_first_addr", 64'(wq[q0].addr), 64'(vt[v].first));
        check("vec_last_addr", 64'(wq[wq.size()-1].addr),
              64'(vt[v].last));
        for (int k = 0; k < wq.size() - q0; k++) begin
          check("vec_data", 64'(wq[q0+k].data), 64'(sv + DW'(k)));
          check("vec_core", 64'(wq[q0+k].core), 64'(c));
        end
      end
    end
    memReady = 1'b1;

    // Simultaneous requests from cores 1 and 3, then 2 and 0
    do_reset();
    g0 = gq.size();
    start(1, 'h020, 0, $urandom);
    start(3, 'h030, 0, $urandom);
    wait_done(3, done_cnt[3], 20, "sim_done3");
    start(2, 'h022, 0, $urandom);
    start(0, 'h011, 0, $urandom);
    wait_done(2, done_cnt[2], 30, "sim_done2");
    check("sim_grant_count", 64'(gq.size() - g0), 64'd4);
    if (gq.size() >= g0 + 4) begin
      check("sim_first", 64'(gq[g0]), 64'd1);
      check("sim_second", 64'(gq[g0+1]), 64'd3);
      check("sim_gap", 64'(gcyc[g0+1] - gcyc[g0]), 64'd4);
      check("sim_wrap", 64'(gq[g0+2]), 64'd0);
      check("sim_fourth", 64'(gq[g0+3]), 64'd2);
    end

    // Fairness with every core requesting continuously
    do_reset();
    g0 = gq.size();
    mode = 1;
    for (int k = 0; k < 40; k++) cyc();
    mode = 0;
    wait_idle(100, "fair_drain");
    check("fair_enough", 64'(gq.size() - g0 >= 8), 64'd1);
    if (gq.size() >= g0 + 8)
      for (int k = 0; k < 8; k++)
        check("fair_order", 64'(gq[g0+k]), 64'(k % 4));

    // Reset in the middle of a burst
    do_reset();
    start(1, 'h300, 0, $urandom);
    wait_done(1, done_cnt[1], 20, "rst_pre_done");
    d0 = done_cnt[2];
    a0 = wq.size();
    start(2, 'h040, 3, $urandom);
    cyc();
    cyc();
    cyc();
    check("rst_mid_store", 64'({memWrite, memAddr}),
          64'({1'b1, 10'h041}));
    #1 rstN = 1'b0;
    #1 check("rst_async_outputs", outs(), 64'd0);
    storeReq = '0;
    cyc();
    for (int i = 0; i < N; i++) widx[i] = 0;
    apply_data();
    cyc();
    rstN = 1'b1;
    check("rst_accepts", 64'(wq.size() - a0), 64'd1);
    check("rst_no_done", 64'(done_cnt[2] - d0), 64'd0);
    g0 = gq.size();
    start(3, 'h060, 0, $urandom);
    start(0, 'h050, 0, $urandom);
    wait_done(0, done_cnt[0], 20, "rst_post_done");
    check("rst_rrptr", 64'(gq.size() > g0 ? gq[g0] : -1), 64'd0);
    wait_idle(40, "rst_drain");

    // Random traffic against the reference model
    mode = 2;
    for (int k = 0; k < 2000; k++) cyc();
    mode = 0;
    memReady = 1'b1;
    wait_idle(400, "rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
